// File: rtl/operand_src_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_src_pipe_if                                                       |
// | Decode-side request, forwarding taps and ALU-side handshake for src1.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface operand_src_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 4,
  parameter int ADDR_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        select;
  logic [WIDTH-1:0]  rn;
  logic [ADDR_W-1:0] rn_addr;
  logic [WIDTH-1:0]  rs;
  logic [ADDR_W-1:0] rs_addr;
  logic [PC_WIDTH-1:0] pc_out;
  logic              fwd_ex_valid;
  logic [ADDR_W-1:0] fwd_ex_addr;
  logic [WIDTH-1:0]  fwd_ex_data;
  logic              fwd_mem_valid;
  logic [ADDR_W-1:0] fwd_mem_addr;
  logic [WIDTH-1:0]  fwd_mem_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  src1;
  logic              src1_fwd;

  modport master (
    output in_valid, select, rn, rn_addr, rs, rs_addr, pc_out,
           fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
           fwd_mem_valid, fwd_mem_addr, fwd_mem_data,
           flush, out_ready,
    input  in_ready, out_valid, src1, src1_fwd
  );

  modport slave (
    input  in_valid, select, rn, rn_addr, rs, rs_addr, pc_out,
           fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
           fwd_mem_valid, fwd_mem_addr, fwd_mem_data,
           flush, out_ready,
    output in_ready, out_valid, src1, src1_fwd
  );
endinterface
`default_nettype wire

// File: rtl/operand_src_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_src_pipe                                                          |
// | ALU src1 select (Rn/Rs/PC/zero) with EX/MEM forwarding, delivered through |
// | a two-entry valid/ready skid buffer. Forwarding exists only when the      |
// | macro OPSEL_FWD_EN is defined.                                            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module operand_src_pipe #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 4,
  parameter int ADDR_W   = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  operand_src_pipe_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  main_data_q, main_data_d;
  logic              main_fwd_q, main_fwd_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic              skid_fwd_q, skid_fwd_d;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_fire;
  logic [WIDTH-1:0]  w_pc_ext;
  logic [WIDTH-1:0]  w_reg_val;
  logic [ADDR_W-1:0] w_reg_addr;
  logic [WIDTH-1:0]  w_opnd;
  logic              w_opnd_fwd;

  // in_ready depends only on registered state and rst, never on out_ready.
  assign w_in_ready  = !rst && (state_q != ST_FULL);
  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
  assign w_fire      = w_out_valid && bus.out_ready;

  assign w_reg_val  = bus.select[0] ? bus.rs      : bus.rn;
  assign w_reg_addr = bus.select[0] ? bus.rs_addr : bus.rn_addr;

`ifdef OPSEL_FWD_EN
  logic w_ex_hit;
  logic w_mem_hit;
  assign w_ex_hit  = bus.fwd_ex_valid  && (bus.fwd_ex_addr  == w_reg_addr);
  assign w_mem_hit = bus.fwd_mem_valid && (bus.fwd_mem_addr == w_reg_addr);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                          bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data,
                          w_reg_addr};
`endif

  always_comb begin
    w_pc_ext                 = '0;
    w_pc_ext[PC_WIDTH-1:0]   = bus.pc_out;
    w_opnd                   = '0;
    w_opnd_fwd               = 1'b0;
    case (bus.select)
      2'b00, 2'b01: begin
`ifdef OPSEL_FWD_EN
        // The younger EX result shadows the older MEM result.
        if (w_ex_hit) begin
          w_opnd     = bus.fwd_ex_data;
          w_opnd_fwd = 1'b1;
        end else if (w_mem_hit) begin
          w_opnd     = bus.fwd_mem_data;
          w_opnd_fwd = 1'b1;
        end else begin
          w_opnd     = w_reg_val;
        end
`else
        w_opnd = w_reg_val;
`endif
      end
      2'b10:   w_opnd = w_pc_ext;
      default: w_opnd = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_fwd_d  = main_fwd_q;
    skid_data_d = skid_data_q;
    skid_fwd_d  = skid_fwd_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          state_d     = ST_ONE;
          main_data_d = w_opnd;
          main_fwd_d  = w_opnd_fwd;
        end
      end
      ST_ONE: begin
        if (w_accept && w_fire) begin
          main_data_d = w_opnd;
          main_fwd_d  = w_opnd_fwd;
        end else if (w_accept) begin
          state_d     = ST_FULL;
          skid_data_d = w_opnd;
          skid_fwd_d  = w_opnd_fwd;
        end else if (w_fire) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_fwd_d  = skid_fwd_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A fire in the flush cycle still completes; everything behind it is lost.
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_fwd_q  <= 1'b0;
      skid_data_q <= '0;
      skid_fwd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_fwd_q  <= main_fwd_d;
      skid_data_q <= skid_data_d;
      skid_fwd_q  <= skid_fwd_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.src1      = main_data_q;
  assign bus.src1_fwd  = main_fwd_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_src_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_operand_src_pipe                                                       |
// | Directed plus random stimulus; queue-based reference and scoreboard.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_operand_src_pipe;

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic [1:0]  sel;
    logic [31:0] rn;
    logic [3:0]  rn_addr;
    logic [31:0] rs;
    logic [3:0]  rs_addr;
    logic [3:0]  pc;
    logic        ex_v;
    logic [3:0]  ex_a;
    logic [31:0] ex_d;
    logic        mem_v;
    logic [3:0]  mem_a;
    logic [31:0] mem_d;
    logic        flush;
    logic        out_ready;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t s;
  logic [32:0] sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_src_pipe_if #(.WIDTH(32), .PC_WIDTH(4), .ADDR_W(4)) bus ();

  operand_src_pipe #(.WIDTH(32), .PC_WIDTH(4), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what src1 must be for this request, straight from the select rules.
  function automatic logic [32:0] ref_operand(input stim_t t);
    logic [31:0] v;
    case (t.sel)
      2'd2: return {1'b0, 28'd0, t.pc};
      2'd3: return 33'd0;
      default: begin
        v = t.sel[0] ? t.rs : t.rn;
`ifdef OPSEL_FWD_EN
        if (t.ex_v && t.ex_a == (t.sel[0] ? t.rs_addr : t.rn_addr))
          return {1'b1, t.ex_d};
        if (t.mem_v && t.mem_a == (t.sel[0] ? t.rs_addr : t.rn_addr))
          return {1'b1, t.mem_d};
`endif
        return {1'b0, v};
      end
    endcase
  endfunction

  task automatic apply();
    rst               = s.rst;
    bus.in_valid      = s.in_valid;
    bus.select        = s.sel;
    bus.rn            = s.rn;
    bus.rn_addr       = s.rn_addr;
    bus.rs            = s.rs;
    bus.rs_addr       = s.rs_addr;
    bus.pc_out        = s.pc;
    bus.fwd_ex_valid  = s.ex_v;
    bus.fwd_ex_addr   = s.ex_a;
    bus.fwd_ex_data   = s.ex_d;
    bus.fwd_mem_valid = s.mem_v;
    bus.fwd_mem_addr  = s.mem_a;
    bus.fwd_mem_data  = s.mem_d;
    bus.flush         = s.flush;
    bus.out_ready     = s.out_ready;
  endtask

  // One cycle: drive at negedge, update the expected queue just after posedge.
  task automatic step();
    logic        acc;
    logic [32:0] exp_val;
    @(negedge clk);
    apply();
    acc     = s.in_valid && !s.rst && !s.flush && (sb.size() < 2);
    exp_val = ref_operand(s);
    @(posedge clk);
    #1;
    if (s.rst || s.flush) sb.delete();
    else if (acc) sb.push_back(exp_val);
  endtask

  // Monitor: compares handshake flags every cycle and pops on each fire.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    chk("out_valid", {32'd0, bus.out_valid}, {32'd0, sb.size() != 0});
    chk("in_ready", {32'd0, bus.in_ready}, {32'd0, !rst && sb.size() < 2});
    if (sb.size() != 0 && bus.out_ready) begin
      e = sb.pop_front();
      chk("src1", {1'b0, bus.src1}, {1'b0, e[31:0]});
      chk("src1_fwd", {32'd0, bus.src1_fwd}, {32'd0, e[32]});
    end
  end

  task automatic idle_stim();
    s = '{rst: 1'b0, in_valid: 1'b0, sel: 2'd0, rn: 32'h11, rn_addr: 4'd3,
          rs: 32'h22, rs_addr: 4'd4, pc: 4'hA, ex_v: 1'b0, ex_a: 4'd0,
          ex_d: 32'hE, mem_v: 1'b0, mem_a: 4'd0, mem_d: 32'hD,
          flush: 1'b0, out_ready: 1'b1};
  endtask

  initial begin
    idle_stim();
    s.rst = 1'b1;
    apply();
    step();
    step();
    s.rst = 1'b0;
    chk("reset_src1", {1'b0, bus.src1}, 33'd0);
    chk("reset_src1_fwd", {32'd0, bus.src1_fwd}, 33'd0);
    chk("reset_out_valid", {32'd0, bus.out_valid}, 33'd0);

    // Basic select sweep
    s.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.sel = i[1:0];
      step();
    end
    s.in_valid = 1'b0;
    step();

    // Forwarding priority: both match, MEM only, none match, Rs via MEM
    s.in_valid = 1'b1; s.sel = 2'd0;
    s.ex_v = 1'b1; s.ex_a = 4'd3; s.mem_v = 1'b1; s.mem_a = 4'd3;
    step();
    s.ex_v = 1'b0;
    step();
    s.mem_a = 4'd5;
    step();
    s.sel = 2'd1; s.mem_a = 4'd4;
    step();
    idle_stim();
    step();

    // Backpressure: three back-to-back requests with out_ready low
    s.out_ready = 1'b0; s.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s.rn = 32'h100 + i;
      step();
    end
    s.in_valid = 1'b0;
    step();
    s.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Flush colliding with accept and fire while full
    s.out_ready = 1'b0; s.in_valid = 1'b1;
    s.rn = 32'hA1; step();
    s.rn = 32'hA2; step();
    s.rn = 32'hA3; s.flush = 1'b1; s.out_ready = 1'b1;
    step();
    s.flush = 1'b0; s.in_valid = 1'b0;
    step();
    step();

    // Reset while full, then a fresh request
    s.out_ready = 1'b0; s.in_valid = 1'b1;
    s.rn = 32'hB1; step();
    s.rn = 32'hB2; step();
    s.rst = 1'b1;
    step();
    chk("midrst_src1", {1'b0, bus.src1}, 33'd0);
    chk("midrst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    chk("midrst_src1_fwd", {32'd0, bus.src1_fwd}, 33'd0);
    s.rst = 1'b0; s.in_valid = 1'b0; s.out_ready = 1'b1;
    step();
    s.in_valid = 1'b1; s.rn = 32'hC1;
    step();
    s.in_valid = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst       = ($urandom_range(0, 63) == 0);
      s.flush     = ($urandom_range(0, 23) == 0);
      s.in_valid  = ($urandom_range(0, 3) != 0);
      s.out_ready = ($urandom_range(0, 2) != 0);
      s.sel       = 2'($urandom_range(0, 3));
      s.rn        = $urandom;
      s.rs        = $urandom;
      s.rn_addr   = 4'($urandom_range(0, 3));
      s.rs_addr   = 4'($urandom_range(0, 3));
      s.pc        = 4'($urandom);
      s.ex_v      = 1'($urandom);
      s.ex_a      = 4'($urandom_range(0, 3));
      s.ex_d      = $urandom;
      s.mem_v     = 1'($urandom);
      s.mem_a     = 4'($urandom_range(0, 3));
      s.mem_d     = $urandom;
      step();
    end

    idle_stim();
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", {1'b0, 32'(sb.size())}, 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_src_pipe.md
# operand_src_pipe

Registered, parametrised successor to the ALU source-1 operand multiplexer. Selects the first ALU operand from Rn, Rs or the zero-extended PC, replaces register operands with in-flight EX/MEM results on an address match, and delivers the result through a two-entry valid/ready skid buffer. It sits between decode and the ALU. Stalls and flushes are absorbed here without dropping or duplicating operands.

## Interface
Parameters:
- WIDTH, 32, operand/data width
- PC_WIDTH, 4, width of PC input; must be ≤ WIDTH
- ADDR_W, 4, register-file address width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  decode presents an operand request
- in_ready  output  1  block can accept a request this cycle
- select  input  2  00 Rn, 01 Rs, 10 PC, 11 constant zero
- rn / rn_addr  input  WIDTH / ADDR_W  Rn value and its register address
- rs / rs_addr  input  WIDTH / ADDR_W  Rs value and its register address
- pc_out  input  PC_WIDTH  PC for jumps
- fwd_ex_valid, fwd_ex_addr, fwd_ex_data  input  1 / ADDR_W / WIDTH  EX-stage result
- fwd_mem_valid, fwd_mem_addr, fwd_mem_data  input  1 / ADDR_W / WIDTH  MEM-stage result
- flush  input  1  discard all buffered operands
- out_valid  output  1  src1 is valid
- out_ready  input  1  ALU consumes src1 this cycle
- src1  output  WIDTH  selected operand
- src1_fwd  output  1  src1 came from a forwarding path

## Operation
- Accept = in_valid && in_ready && !flush. Fire = out_valid && out_ready.
- Operand is resolved combinationally at accept and stored with src1_fwd.
  - select 00/01: the operand address is rn_addr or rs_addr.
  - EX match (fwd_ex_valid && fwd_ex_addr == addr) gives fwd_ex_data. Otherwise a MEM match gives fwd_mem_data. Otherwise the register value is used.
  - EX takes priority over MEM when both match.
- select 10: src1 = {zeros, pc_out}, src1_fwd = 0.
- select 11: src1 = 0, src1_fwd = 0.
- Storage has two entries: main (drives outputs) and skid. State is EMPTY, ONE or FULL.
  - EMPTY: accept → ONE, and the request loads main.
  - ONE: accept with fire → ONE, and main is reloaded. Accept without fire → FULL, and the request loads skid. Fire without accept → EMPTY.
  - FULL: fire → ONE, and skid moves to main. No accept is possible.
- Order is strictly preserved. Each accepted request fires exactly once unless it is flushed.
- in_ready = !rst && state != FULL. out_valid = state != EMPTY.
- flush: next state EMPTY and both entries are invalidated. flush beats a simultaneous accept (the request is dropped) and a simultaneous fire (the ALU sees that fire, then nothing).
- Reset values: state EMPTY, out_valid 0, src1 0, src1_fwd 0. Requests presented during rst are ignored.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on src1/out_valid after edge N.
- Throughput is one operand per cycle with out_ready held high.
- Forwarding inputs are sampled only in the accept cycle. Later changes do not alter a stored operand.
- in_ready falls the cycle after the skid fills, with no combinational path from out_ready. It rises the cycle after a fire from FULL.
- While out_valid=1 and out_ready=0, src1 and src1_fwd hold stable.
- Reset asserted mid-operation empties the buffer at that edge. Outputs take reset values on the following cycle.

## Configuration
- OPSEL_FWD_EN defined: forwarding logic is present as described.
- OPSEL_FWD_EN undefined:
  - Forwarding ports are unconnected internally.
  - Register operands always come from rn/rs.
  - src1_fwd is constant 0.
  - Skid, flush and handshake behaviour is unchanged.

## Test plan
- Basic select: select=00,01,10,11 with rn=0x11, rs=0x22, pc_out=0xA and out_ready=1 → src1 is 0x11, 0x22, 0x0000000A, 0 on consecutive cycles, each one cycle after its accept.
- Forward priority: rn_addr=3, EX addr 3 data 0xE, MEM addr 3 data 0xD → src1=0xE, src1_fwd=1. With EX invalid → 0xD. With neither matching → rn. With the macro undefined → rn and src1_fwd=0.
- Backpressure: out_ready=0 with 3 back-to-back requests → first two buffered, in_ready=0 after the second. With out_ready=1 they deliver in order and in_ready returns 1.
- Flush collision: FULL, then flush plus in_valid plus out_ready in one cycle → the next cycle shows out_valid=0 and in_ready=1, and the flushed request never appears.
- Reset mid-stream: rst for one cycle while FULL → src1=0, out_valid=0, src1_fwd=0. A new request one cycle after rst deasserts completes with 1-cycle latency.
